// File: rtl/fft_mag_pkg.sv
// ============================================================================
// fft_mag_pkg: shared state encoding, defaults and width helper for fft_mag_stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fft_mag_pkg;

   typedef enum logic [1:0] {
      WAIT_SOP = 2'd0,
      IN_FRAME = 2'd1,
      PAD      = 2'd2,
      DISCARD  = 2'd3
   } state_t;

   localparam int DW_DEFAULT       = 16;
   localparam int NSAMPLES_DEFAULT = 1024;

   function automatic int mag_width(input int dw);
      return 2 * dw + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fft_mag_sq_pipe.sv
// ============================================================================
// fft_mag_sq_pipe: 3-stage re^2+im^2 datapath; DC blanking under FFT_MAG_DC_BLANK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_mag_sq_pipe
   import fft_mag_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int W  = mag_width(DW)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   input  logic                 in_valid,
   input  logic                 in_first,
   output logic [W-1:0]         mag,
   output logic                 mag_valid
);

`ifdef FFT_MAG_DC_BLANK_EN
   localparam logic C_DC_BLANK = 1'b1;
`else
   localparam logic C_DC_BLANK = 1'b0;
`endif

   logic signed [DW-1:0]   re1, im1;
   logic signed [2*DW-1:0] p_re, p_im;
   logic                   v1, v2, first1, first2;
   logic [W-1:0]           sum;

   // Products are non-negative, so zero-extension to W is exact.
   assign sum = {{(W-2*DW){1'b0}}, p_re} + {{(W-2*DW){1'b0}}, p_im};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         re1       <= '0;
         im1       <= '0;
         v1        <= 1'b0;
         first1    <= 1'b0;
         p_re      <= '0;
         p_im      <= '0;
         v2        <= 1'b0;
         first2    <= 1'b0;
         mag       <= '0;
         mag_valid <= 1'b0;
      end else begin
         re1       <= in_re;
         im1       <= in_im;
         v1        <= in_valid;
         first1    <= in_valid & in_first;
         p_re      <= re1 * re1;
         p_im      <= im1 * im1;
         v2        <= v1;
         first2    <= first1;
         mag       <= (C_DC_BLANK && first2) ? '0 : sum;
         mag_valid <= v2;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fft_mag_stream.sv
// ============================================================================
// fft_mag_stream: frame-enforcing |X|^2 stream producer (pad short, truncate long).
// Optional macro FFT_MAG_DC_BLANK_EN zeroes bin 0.  Revision: 1.0
// ============================================================================
`default_nettype none

module fft_mag_stream
   import fft_mag_pkg::*;
#(
   parameter int NSamples = NSAMPLES_DEFAULT,
   parameter int DW       = DW_DEFAULT,
   parameter int W        = mag_width(DW),
   parameter int NBits    = $clog2(NSamples)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   input  logic                 in_valid,
   input  logic                 in_sop,
   input  logic                 in_eop,
   output logic                 in_ready,
   output logic [W-1:0]         mag,
   output logic                 mag_valid,
   output logic                 frame_err,
   output logic [7:0]           err_count
);

   localparam logic [NBits-1:0] C_LAST = NBits'(NSamples - 1);

   state_t               state, state_nxt;
   logic [NBits-1:0]     cnt, cnt_nxt;
   logic                 accept, push, err;
   logic signed [DW-1:0] push_re, push_im;

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= WAIT_SOP;
         cnt       <= '0;
         in_ready  <= 1'b1;
         frame_err <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         in_ready  <= (state_nxt != PAD);
         frame_err <= err;
         if (err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      push      = 1'b0;
      err       = 1'b0;
      push_re   = in_re;
      push_im   = in_im;
      case (state)
         WAIT_SOP: begin
            if (accept) begin
               if (in_sop) begin
                  push      = 1'b1;
                  cnt_nxt   = NBits'(1);
                  state_nxt = in_eop ? PAD : IN_FRAME;
               end else begin
                  err = 1'b1;
               end
            end
         end
         IN_FRAME: begin
            if (accept) begin
               push = 1'b1;
               // A stray sop is kept as ordinary data; only flagged.
               if (in_sop)
                  err = 1'b1;
               if (cnt == C_LAST) begin
                  cnt_nxt = '0;
                  if (in_eop) begin
                     state_nxt = WAIT_SOP;
                  end else begin
                     state_nxt = DISCARD;
                     err       = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
                  if (in_eop) begin
                     state_nxt = PAD;
                     err       = 1'b1;
                  end
               end
            end
         end
         PAD: begin
            push    = 1'b1;
            push_re = '0;
            push_im = '0;
            if (cnt == C_LAST) begin
               cnt_nxt   = '0;
               state_nxt = WAIT_SOP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DISCARD: begin
            if (accept) begin
               if (in_eop) begin
                  state_nxt = WAIT_SOP;
               end else if (in_sop) begin
                  push      = 1'b1;
                  err       = 1'b1;
                  cnt_nxt   = NBits'(1);
                  state_nxt = IN_FRAME;
               end
            end
         end
         default: state_nxt = WAIT_SOP;
      endcase
   end

   fft_mag_sq_pipe #(
      .DW (DW),
      .W  (W)
   ) u_sq_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_re     (push_re),
      .in_im     (push_im),
      .in_valid  (push),
      .in_first  (cnt == '0),
      .mag       (mag),
      .mag_valid (mag_valid)
   );

endmodule

`default_nettype wire
